hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide and HI/LO register unit sitting directly downstream of the instruction decoder.
- Consumes the decoder's 55-bit one-hot instruction_type plus the rs/rt operands.
- Executes MULT/MULTU/DIV/DIVU/MUL iteratively (32 iterations) and MTHI/MTLO in a single cycle.
- Exposes HI, LO and the MUL result; the control unit stalls on busy.

---
 rtl/hilo_muldiv_if.sv | 26 ++
 rtl/hilo_muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the instruction decoder / control unit and the HI/LO multiply-divide unit.
// The decoder side drives the issue fields; the unit drives status and the HI/LO/MUL results.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic [54:0]      instruction_type;
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mul_result;

    modport master (
        output instruction_type, start, flush, rs_data, rt_data,
        input  busy, done, hi, lo, mul_result
    );

    modport slave (
        input  instruction_type, start, flush, rs_data, rt_data,
        output busy, done, hi, lo, mul_result
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
// Runs shift-add multiply or restoring divide on magnitudes and sign-fixes in FINISH.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hilo_muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [54:0] USED_MASK = (55'd1 << 31) | (55'd1 << 32) | (55'd1 << 33) |
                                        (55'd1 << 34) | (55'd1 << 48) | (55'd1 << 49) |
                                        (55'd1 << 54);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    typedef enum logic [2:0] {
        OP_NONE, OP_DIV, OP_DIVU, OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO, OP_MUL
    } op_t;

    state_t             state_reg;
    op_t                op_reg;
    logic [CNT_W-1:0]   counter_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic               neg_result_reg;
    logic               neg_rem_reg;
    logic               div_zero_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   mul_result_reg;
    logic               done_reg;

    logic [54:0]        used_hot;
    op_t                op_sel;
    logic               accept;
    logic               signed_sel;
    logic               div_sel;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;

    logic               op_is_div;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] product_fixed;
    logic [WIDTH-1:0]   quotient_fixed;
    logic [WIDTH-1:0]   remainder_fixed;

    function automatic op_t bit_to_op(input int idx);
        case (idx)
            31:      return OP_DIV;
            32:      return OP_DIVU;
            33:      return OP_MULT;
            34:      return OP_MULTU;
            48:      return OP_MTHI;
            49:      return OP_MTLO;
            54:      return OP_MUL;
            default: return OP_NONE;
        endcase
    endfunction

    // Scan downwards so the lowest-index used bit is the last (winning) assignment.
    assign used_hot = bus.instruction_type & USED_MASK;

    always_comb begin
        op_sel = OP_NONE;
        for (int i = 54; i >= 0; i--) begin
            if (used_hot[i]) begin
                op_sel = bit_to_op(i);
            end
        end
    end

    assign accept     = bus.start && !bus.flush && (state_reg == IDLE);
    assign signed_sel = (op_sel == OP_DIV) || (op_sel == OP_MULT) || (op_sel == OP_MUL);
    assign div_sel    = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    assign rs_abs     = (signed_sel && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    assign rt_abs     = (signed_sel && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign op_is_div = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
    assign mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, operand_reg} : '0);
    assign mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, operand_reg};
    assign div_diff  = div_shift[WIDTH-1:0] - operand_reg;
    assign div_next  = div_ge ? {div_diff, acc_reg[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    // A zero divisor leaves |rs| as remainder, so the dividend-sign fix restores rs exactly.
    assign product_fixed   = neg_result_reg ? -acc_reg : acc_reg;
    assign quotient_fixed  = div_zero_reg ? '1 :
                             (neg_result_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]);
    assign remainder_fixed = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            op_reg         <= OP_NONE;
            counter_reg    <= '0;
            acc_reg        <= '0;
            operand_reg    <= '0;
            neg_result_reg <= 1'b0;
            neg_rem_reg    <= 1'b0;
            div_zero_reg   <= 1'b0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            mul_result_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        case (op_sel)
                            OP_MTHI: hi_reg <= bus.rs_data;
                            OP_MTLO: lo_reg <= bus.rs_data;
                            OP_DIV, OP_DIVU, OP_MULT, OP_MULTU, OP_MUL: begin
                                state_reg      <= CALC;
                                op_reg         <= op_sel;
                                counter_reg    <= '0;
                                acc_reg        <= {{WIDTH{1'b0}}, (div_sel ? rs_abs : rt_abs)};
                                operand_reg    <= div_sel ? rt_abs : rs_abs;
                                neg_result_reg <= signed_sel && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                                neg_rem_reg    <= signed_sel && bus.rs_data[WIDTH-1];
                                div_zero_reg   <= (bus.rt_data == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state_reg <= IDLE;
                    end else begin
                        acc_reg     <= op_is_div ? div_next : mul_next;
                        counter_reg <= counter_reg + 1'b1;
                        if (counter_reg == CNT_W'(WIDTH - 1)) begin
                            state_reg <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                    if (!bus.flush) begin
                        done_reg <= 1'b1;
                        case (op_reg)
                            OP_MULT, OP_MULTU: begin
                                hi_reg <= product_fixed[2*WIDTH-1:WIDTH];
                                lo_reg <= product_fixed[WIDTH-1:0];
                            end
                            OP_DIV, OP_DIVU: begin
                                lo_reg <= quotient_fixed;
                                hi_reg <= remainder_fixed;
                            end
                            OP_MUL:  mul_result_reg <= product_fixed[WIDTH-1:0];
                            default: ;
                        endcase
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state_reg != IDLE);
    assign bus.done       = done_reg;
    assign bus.hi         = hi_reg;
    assign bus.lo         = lo_reg;
    assign bus.mul_result = mul_result_reg;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed scenarios plus randomized
// instructions checked against a plain-arithmetic HI/LO/MUL reference model.
module tb_hilo_muldiv_unit;
    localparam int B_DIV = 31, B_DIVU = 32, B_MULT = 33, B_MULTU = 34;
    localparam int B_MTHI = 48, B_MTLO = 49, B_MUL = 54;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic [31:0] exp_mul = '0;

    hilo_muldiv_if #(.WIDTH(32)) bus_if ();

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [54:0] it, input logic [31:0] rs, input logic [31:0] rt);
        bus_if.instruction_type = it;
        bus_if.rs_data = rs;
        bus_if.rt_data = rt;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        bus_if.instruction_type = '0;
    endtask

    function automatic logic [54:0] onehot(input int idx);
        logic [54:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Waits for done starting from cycle start_cyc; bounded, caller checks the result.
    task automatic wait_done(input int start_cyc, output int cyc, output int busy_cnt);
        cyc = start_cyc;
        busy_cnt = 0;
        while (bus_if.done !== 1'b1 && cyc < 100) begin
            if (bus_if.busy === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    // Reference model: lowest used bit wins, results from plain 64-bit arithmetic.
    function automatic int pick_op(input logic [54:0] it);
        int order[7] = '{B_DIV, B_DIVU, B_MULT, B_MULTU, B_MTHI, B_MTLO, B_MUL};
        foreach (order[k]) if (it[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic model_exec(input int op, input logic [31:0] rs, input logic [31:0] rt);
        longint      a, b, q, r, p;
        logic [63:0] pu;
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        case (op)
            B_DIV: begin
                if (rt == 0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = rs; end
                else begin q = a / b; r = a % b; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            end
            B_DIVU: begin
                if (rt == 0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = rs; end
                else begin exp_lo = rs / rt; exp_hi = rs % rt; end
            end
            B_MULT:  begin p = a * b; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            B_MULTU: begin pu = {32'b0, rs} * {32'b0, rt}; exp_hi = pu[63:32]; exp_lo = pu[31:0]; end
            B_MTHI:  exp_hi = rs;
            B_MTLO:  exp_lo = rs;
            B_MUL:   begin p = a * b; exp_mul = p[31:0]; end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        bus_if.start = 1'b0; bus_if.flush = 1'b0;
        bus_if.instruction_type = '0; bus_if.rs_data = '0; bus_if.rt_data = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tests_run++; if (bus_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        tests_run++; if (bus_if.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus_if.done); end
        tests_run++; if (bus_if.hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", bus_if.hi); end
        tests_run++; if (bus_if.lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", bus_if.lo); end
        tests_run++; if (bus_if.mul_result !== 32'h0) begin tests_failed++; $display("FAIL reset_mul: got %h expected 0", bus_if.mul_result); end
    endtask

    task automatic test_multiply();
        int cyc, bc;
        issue(onehot(B_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        model_exec(B_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, cyc, bc);
        tests_run++; if (cyc !== 34) begin tests_failed++; $display("FAIL multu_done_cycle: got %0d expected 34", cyc); end
        tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
        tests_run++; if (bus_if.hi !== 32'hFFFF_FFFE || bus_if.lo !== 32'h0000_0001) begin
            tests_failed++; $display("FAIL multu_result: got hi=%h lo=%h expected hi=fffffffe lo=00000001", bus_if.hi, bus_if.lo); end
        tick();
        tests_run++; if (bus_if.done !== 1'b0) begin tests_failed++; $display("FAIL done_pulse_width: got %b expected 0", bus_if.done); end

        issue(onehot(B_MULT), 32'hFFFF_FFFD, 32'd7);
        model_exec(B_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(1, cyc, bc);
        tests_run++; if (bus_if.hi !== 32'hFFFF_FFFF || bus_if.lo !== 32'hFFFF_FFEB) begin
            tests_failed++; $display("FAIL mult_result: got hi=%h lo=%h expected hi=ffffffff lo=ffffffeb", bus_if.hi, bus_if.lo); end

        issue(onehot(B_MUL), 32'd6, 32'hFFFF_FFFE);
        model_exec(B_MUL, 32'd6, 32'hFFFF_FFFE);
        wait_done(1, cyc, bc);
        tests_run++; if (bus_if.mul_result !== 32'hFFFF_FFF4) begin
            tests_failed++; $display("FAIL mul_result: got %h expected fffffff4", bus_if.mul_result); end
        tests_run++; if (bus_if.hi !== 32'hFFFF_FFFF || bus_if.lo !== 32'hFFFF_FFEB) begin
            tests_failed++; $display("FAIL mul_hilo_kept: got hi=%h lo=%h expected hi=ffffffff lo=ffffffeb", bus_if.hi, bus_if.lo); end
    endtask

    task automatic test_divide();
        int cyc, bc;
        logic [31:0] vec_rs[4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5};
        logic [31:0] vec_rt[4] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        int          vec_op[4] = '{B_DIV, B_DIVU, B_DIV, B_DIVU};
        logic [31:0] want_lo[4] = '{32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] want_hi[4] = '{32'hFFFF_FFFF, 32'd1, 32'h0, 32'd5};
        for (int k = 0; k < 4; k++) begin
            issue(onehot(vec_op[k]), vec_rs[k], vec_rt[k]);
            model_exec(vec_op[k], vec_rs[k], vec_rt[k]);
            wait_done(1, cyc, bc);
            tests_run++; if (bus_if.lo !== want_lo[k] || bus_if.hi !== want_hi[k]) begin
                tests_failed++; $display("FAIL div_case%0d: got lo=%h hi=%h expected lo=%h hi=%h",
                                         k, bus_if.lo, bus_if.hi, want_lo[k], want_hi[k]); end
        end
        issue(onehot(B_DIV), 32'hFFFF_FFF3, 32'd0);
        model_exec(B_DIV, 32'hFFFF_FFF3, 32'd0);
        wait_done(1, cyc, bc);
        tests_run++; if (bus_if.lo !== 32'hFFFF_FFFF || bus_if.hi !== 32'hFFFF_FFF3) begin
            tests_failed++; $display("FAIL div_signed_by_zero: got lo=%h hi=%h expected lo=ffffffff hi=fffffff3", bus_if.lo, bus_if.hi); end
    endtask

    task automatic test_mthi_mtlo();
        issue(onehot(B_MTHI), 32'h1234_5678, 32'h0);
        model_exec(B_MTHI, 32'h1234_5678, 32'h0);
        tests_run++; if (bus_if.hi !== 32'h1234_5678) begin tests_failed++; $display("FAIL mthi_value: got %h expected 12345678", bus_if.hi); end
        tests_run++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            tests_failed++; $display("FAIL mthi_no_busy: got busy=%b done=%b expected 0 0", bus_if.busy, bus_if.done); end
        issue(onehot(B_MTLO), 32'hA5A5_0F0F, 32'h0);
        model_exec(B_MTLO, 32'hA5A5_0F0F, 32'h0);
        tests_run++; if (bus_if.lo !== 32'hA5A5_0F0F || bus_if.hi !== 32'h1234_5678) begin
            tests_failed++; $display("FAIL mtlo_value: got lo=%h hi=%h expected lo=a5a50f0f hi=12345678", bus_if.lo, bus_if.hi); end
    endtask

    task automatic test_busy_ignore();
        int cyc, bc;
        issue(onehot(B_MULTU), 32'h0001_0003, 32'h0000_0105);
        model_exec(B_MULTU, 32'h0001_0003, 32'h0000_0105);
        tick(); tick();
        issue(onehot(B_MTLO), 32'hDEAD_BEEF, 32'h0);
        tests_run++; if (bus_if.lo === 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL mtlo_while_busy: got %h expected not deadbeef", bus_if.lo); end
        wait_done(4, cyc, bc);
        tests_run++; if (cyc !== 34) begin tests_failed++; $display("FAIL busy_ignore_done_cycle: got %0d expected 34", cyc); end
        tests_run++; if (bus_if.lo !== exp_lo || bus_if.hi !== exp_hi) begin
            tests_failed++; $display("FAIL busy_ignore_result: got hi=%h lo=%h expected hi=%h lo=%h", bus_if.hi, bus_if.lo, exp_hi, exp_lo); end
        issue(onehot(B_MTLO), 32'hCAFE_F00D, 32'h0);
        model_exec(B_MTLO, 32'hCAFE_F00D, 32'h0);
        tests_run++; if (bus_if.lo !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL mtlo_in_done_cycle: got %h expected cafef00d", bus_if.lo); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        issue(onehot(B_MULT), 32'h0000_1234, 32'hFFFF_0001);
        model_exec(B_MULT, 32'h0000_1234, 32'hFFFF_0001);
        wait_done(1, cyc, bc);
        issue(onehot(B_DIV), 32'hFFFF_0000, 32'd9);
        model_exec(B_DIV, 32'hFFFF_0000, 32'd9);
        wait_done(1, cyc, bc);
        tests_run++; if (cyc !== 34) begin tests_failed++; $display("FAIL b2b_done_cycle: got %0d expected 34", cyc); end
        tests_run++; if (bus_if.lo !== exp_lo || bus_if.hi !== exp_hi) begin
            tests_failed++; $display("FAIL b2b_result: got hi=%h lo=%h expected hi=%h lo=%h", bus_if.hi, bus_if.lo, exp_hi, exp_lo); end
    endtask

    task automatic test_flush();
        int done_seen;
        issue(onehot(B_DIVU), 32'd1000, 32'd7);
        repeat (4) tick();
        bus_if.flush = 1'b1;
        tick();
        bus_if.flush = 1'b0;
        tests_run++; if (bus_if.busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b expected 0", bus_if.busy); end
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus_if.done === 1'b1) done_seen++;
            tick();
        end
        tests_run++; if (done_seen !== 0) begin tests_failed++; $display("FAIL flush_no_done: got %0d done pulses expected 0", done_seen); end
        tests_run++; if (bus_if.hi !== exp_hi || bus_if.lo !== exp_lo || bus_if.mul_result !== exp_mul) begin
            tests_failed++; $display("FAIL flush_retained: got hi=%h lo=%h mul=%h expected hi=%h lo=%h mul=%h",
                                     bus_if.hi, bus_if.lo, bus_if.mul_result, exp_hi, exp_lo, exp_mul); end
    endtask

    task automatic test_async_reset();
        int cyc, bc;
        issue(onehot(B_DIV), 32'hFFFF_FF00, 32'd3);
        repeat (9) tick();
        #3;
        rst_n = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0; exp_mul = '0;
        tests_run++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset_busy: got busy=%b done=%b expected 0 0", bus_if.busy, bus_if.done); end
        tests_run++; if (bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0 || bus_if.mul_result !== 32'h0) begin
            tests_failed++; $display("FAIL async_reset_regs: got hi=%h lo=%h mul=%h expected 0", bus_if.hi, bus_if.lo, bus_if.mul_result); end
        tick();
        rst_n = 1'b1;
        tick();
        issue(onehot(B_MULTU), 32'd2, 32'd3);
        model_exec(B_MULTU, 32'd2, 32'd3);
        wait_done(1, cyc, bc);
        tests_run++; if (cyc !== 34 || bus_if.lo !== 32'd6 || bus_if.hi !== 32'd0) begin
            tests_failed++; $display("FAIL post_reset_multu: got cyc=%0d hi=%h lo=%h expected cyc=34 hi=0 lo=6", cyc, bus_if.hi, bus_if.lo); end
    endtask

    task automatic test_random();
        int          cyc, bc, op, mode;
        int          used[7] = '{B_DIV, B_DIVU, B_MULT, B_MULTU, B_MTHI, B_MTLO, B_MUL};
        logic [54:0] used_mask, it;
        logic [31:0] rs, rt;
        used_mask = '0;
        foreach (used[k]) used_mask[used[k]] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 3);
            it = '0;
            if (mode == 1) begin
                foreach (used[k]) if ($urandom_range(0, 1) == 1) it[used[k]] = 1'b1;
            end else if (mode == 2) begin
                it = {23'($urandom), $urandom} & ~used_mask;
            end else begin
                it[used[$urandom_range(0, 6)]] = 1'b1;
            end
            rs = rand_operand();
            rt = rand_operand();
            op = pick_op(it);
            issue(it, rs, rt);
            model_exec(op, rs, rt);
            if (op == B_DIV || op == B_DIVU || op == B_MULT || op == B_MULTU || op == B_MUL) begin
                wait_done(1, cyc, bc);
                tests_run++; if (cyc !== 34) begin tests_failed++; $display("FAIL rand%0d_latency: got %0d expected 34", n, cyc); end
            end else begin
                tests_run++; if (bus_if.busy !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_busy: got %b expected 0", n, bus_if.busy); end
            end
            tests_run++; if (bus_if.hi !== exp_hi || bus_if.lo !== exp_lo || bus_if.mul_result !== exp_mul) begin
                tests_failed++; $display("FAIL rand%0d_op%0d rs=%h rt=%h: got hi=%h lo=%h mul=%h expected hi=%h lo=%h mul=%h",
                                         n, op, rs, rt, bus_if.hi, bus_if.lo, bus_if.mul_result, exp_hi, exp_lo, exp_mul); end
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_mthi_mtlo();
        test_busy_ignore();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
